// File: rtl/cache_mem_arbiter_if.sv
// Bundle of cache-side and memory-side signals for cache_mem_arbiter.
// slave = arbiter view, master = caches plus memory model view.
interface cache_mem_arbiter_if #(
    parameter int CACHE_B = 4
);
    localparam int BURST_LEN = 2 ** (CACHE_B - 2);
    localparam int COUNT_W   = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;

    logic               i_req;
    logic               i_we;
    logic [31:0]        i_addr;
    logic [31:0]        i_wdata;
    logic               i_gnt;
    logic               i_beat;
    logic               i_done;

    logic               d_req;
    logic               d_we;
    logic [31:0]        d_addr;
    logic [31:0]        d_wdata;
    logic               d_gnt;
    logic               d_beat;
    logic               d_done;

    logic [COUNT_W-1:0] count;
    logic [31:0]        rdata;

    logic               mem_en;
    logic               mem_we;
    logic [31:0]        mem_addr;
    logic [31:0]        mem_wdata;
    logic [31:0]        mem_rdata;
    logic               mem_ready;

    modport slave (
        input  i_req, i_we, i_addr, i_wdata,
        input  d_req, d_we, d_addr, d_wdata,
        input  mem_rdata, mem_ready,
        output i_gnt, i_beat, i_done,
        output d_gnt, d_beat, d_done,
        output count, rdata,
        output mem_en, mem_we, mem_addr, mem_wdata
    );

    modport master (
        output i_req, i_we, i_addr, i_wdata,
        output d_req, d_we, d_addr, d_wdata,
        output mem_rdata, mem_ready,
        input  i_gnt, i_beat, i_done,
        input  d_gnt, d_beat, d_done,
        input  count, rdata,
        input  mem_en, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/cache_mem_arbiter.sv
// Grants the single memory port to the I- or D-cache for one whole line burst at a time.
// Define DCACHE_PRIORITY_EN for fixed D-cache priority; default is round-robin.
module cache_mem_arbiter #(
    parameter int CACHE_B = 4
) (
    input  logic              clk,
    input  logic              reset_n,
    cache_mem_arbiter_if.slave bus
);
    localparam int BURST_LEN = 2 ** (CACHE_B - 2);
    localparam int COUNT_W   = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
    localparam logic [COUNT_W-1:0] LAST_BEAT = COUNT_W'(BURST_LEN - 1);
    localparam logic [31:0] LINE_MASK = ~((32'd1 << CACHE_B) - 32'd1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        BURST_I = 2'd1,
        BURST_D = 2'd2
    } state_t;

    state_t             state_reg;
    logic [COUNT_W-1:0] count_reg;
    logic [31:0]        base_reg;
    logic               we_reg;
    logic               last_d_reg;
    logic               i_gnt_reg;
    logic               d_gnt_reg;

    logic own_i;
    logic own_d;
    logic busy;
    logic is_last;
    logic pick_d;

    assign own_i   = (state_reg == BURST_I);
    assign own_d   = (state_reg == BURST_D);
    assign busy    = own_i | own_d;
    assign is_last = (count_reg == LAST_BEAT);

`ifdef DCACHE_PRIORITY_EN
    assign pick_d = bus.d_req;
`else
    // Round-robin: on a tie the side that did not own the last burst wins.
    assign pick_d = bus.d_req & (~bus.i_req | ~last_d_reg);
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg  <= IDLE;
            count_reg  <= '0;
            base_reg   <= '0;
            we_reg     <= 1'b0;
            last_d_reg <= 1'b1;
            i_gnt_reg  <= 1'b0;
            d_gnt_reg  <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (bus.i_req | bus.d_req) begin
                        count_reg <= '0;
                        if (pick_d) begin
                            state_reg <= BURST_D;
                            d_gnt_reg <= 1'b1;
                            base_reg  <= bus.d_addr & LINE_MASK;
                            we_reg    <= bus.d_we;
                        end else begin
                            state_reg <= BURST_I;
                            i_gnt_reg <= 1'b1;
                            base_reg  <= bus.i_addr & LINE_MASK;
                            we_reg    <= bus.i_we;
                        end
                    end
                end
                default: begin
                    if (bus.mem_ready) begin
                        if (is_last) begin
                            state_reg  <= IDLE;
                            count_reg  <= '0;
                            i_gnt_reg  <= 1'b0;
                            d_gnt_reg  <= 1'b0;
                            last_d_reg <= own_d;
                        end else begin
                            count_reg <= count_reg + COUNT_W'(1);
                        end
                    end
                end
            endcase
        end
    end

    assign bus.i_gnt     = i_gnt_reg;
    assign bus.d_gnt     = d_gnt_reg;
    assign bus.i_beat    = own_i & bus.mem_ready;
    assign bus.d_beat    = own_d & bus.mem_ready;
    assign bus.i_done    = own_i & bus.mem_ready & is_last;
    assign bus.d_done    = own_d & bus.mem_ready & is_last;
    assign bus.count     = count_reg;
    assign bus.rdata     = busy ? bus.mem_rdata : 32'd0;
    assign bus.mem_en    = busy;
    assign bus.mem_we    = busy & we_reg;
    assign bus.mem_addr  = busy ? (base_reg + (32'(count_reg) << 2)) : 32'd0;
    assign bus.mem_wdata = own_i ? bus.i_wdata : (own_d ? bus.d_wdata : 32'd0);
endmodule
